// File: rtl/demux_1x2_16bit_reg_pkg.sv
// Shared definitions for the registered 1-to-2 demultiplexer.
//   WIDTH_DEFAULT : default data word width
//   CNT_W_DEFAULT : default width of the per-output delivered counters
//   ROUTE_A/B     : encoding of the route select input s
package demux_1x2_16bit_reg_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned CNT_W_DEFAULT = 8;

  localparam logic ROUTE_A = 1'b0;
  localparam logic ROUTE_B = 1'b1;

endpackage : demux_1x2_16bit_reg_pkg

// File: rtl/demux_1x2_16bit_reg_if.sv
// Bus interface of the demultiplexer.
//   Input side : E, s, in_valid, in_data (driven by producer), in_ready (to producer)
//   Output A   : a_valid, a_data, a_count (to consumer A), a_ready (from consumer A)
//   Output B   : b_valid, b_data, b_count (to consumer B), b_ready (from consumer B)
// Modport slave is taken by the demultiplexer, master by the surrounding
// environment (producer plus both consumers).
interface demux_1x2_16bit_reg_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);

  logic             E;
  logic             s;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic [CNT_W-1:0] a_count;

  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic [CNT_W-1:0] b_count;

  modport slave (
    input  E, s, in_valid, in_data, a_ready, b_ready,
    output in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
  );

  modport master (
    output E, s, in_valid, in_data, a_ready, b_ready,
    input  in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
  );

endinterface : demux_1x2_16bit_reg_if

// File: rtl/demux_1x2_16bit_reg_out_slot.sv
// One-entry registered output slot with valid/ready handshake and a
// delivered-word counter.
//   clk, rst   : clock, synchronous active-high reset
//   load       : write load_data into the slot this cycle (only when free)
//   load_data  : word to store
//   ready      : consumer takes the held word this cycle
//   free       : slot can take a new word this cycle (empty, or draining now)
//   valid/data : held word and its valid flag
//   count      : words delivered, wrapping modulo 2^CNT_W
module demux_1x2_16bit_reg_out_slot #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             free,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             take_s;

  // A ready seen while empty is ignored because take requires valid.
  assign take_s = valid_q & ready;
  assign free   = ~valid_q | ready;

  // Next-state: load wins over drain so a drain-and-refill keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (take_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (take_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Slot state registers; data is deliberately not cleared on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign count = count_q;

endmodule : demux_1x2_16bit_reg_out_slot

// File: rtl/demux_1x2_16bit_reg.sv
// Registered 1-to-2 demultiplexer. Each accepted input word is steered by s
// into output slot A (s=0) or B (s=1); each slot holds one word behind a
// valid/ready handshake so a stalled branch never blocks or corrupts the other.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave modport carrying the input handshake, both output
//              handshakes and the per-output delivered counters
module demux_1x2_16bit_reg
  import demux_1x2_16bit_reg_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_1x2_16bit_reg_if.slave  bus
);

  logic a_free_s, b_free_s;
  logic in_ready_s, accept_s;
  logic load_a_s, load_b_s;

  // Steering: readiness looks only at the selected slot, never at in_valid.
  always_comb begin
    in_ready_s = 1'b0;
    load_a_s   = 1'b0;
    load_b_s   = 1'b0;
    if (bus.E) begin
      case (bus.s)
        ROUTE_A: in_ready_s = a_free_s;
        ROUTE_B: in_ready_s = b_free_s;
        default: in_ready_s = 1'b0;
      endcase
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = bus.in_valid & in_ready_s;
    if (accept_s) begin
      load_a_s = (bus.s == ROUTE_A);
      load_b_s = (bus.s == ROUTE_B);
    end else begin
      load_a_s = 1'b0;
      load_b_s = 1'b0;
    end
  end

  assign bus.in_ready = in_ready_s;

  demux_1x2_16bit_reg_out_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a_s),
    .load_data (bus.in_data),
    .ready     (bus.a_ready),
    .free      (a_free_s),
    .valid     (bus.a_valid),
    .data      (bus.a_data),
    .count     (bus.a_count)
  );

  demux_1x2_16bit_reg_out_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b_s),
    .load_data (bus.in_data),
    .ready     (bus.b_ready),
    .free      (b_free_s),
    .valid     (bus.b_valid),
    .data      (bus.b_data),
    .count     (bus.b_count)
  );

endmodule : demux_1x2_16bit_reg

// File: tb/tb_demux_1x2_16bit_reg.sv
// Directed self-checking bench for demux_1x2_16bit_reg.
module tb_demux_1x2_16bit_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  demux_1x2_16bit_reg_if #(.WIDTH(16), .CNT_W(8)) bus ();

  demux_1x2_16bit_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.E = 1'b1; bus.s = 1'b0; bus.in_valid = 1'b0;
    bus.in_data = 16'h0000; bus.a_ready = 1'b0; bus.b_ready = 1'b0;
    step(); step();
    rst = 1'b0; #1;
    n_checks++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got %b want 0", bus.a_valid); end
    n_checks++; if (bus.b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid got %b want 0", bus.b_valid); end
    n_checks++; if (bus.a_data !== 16'h0000) begin n_fail++; $display("FAIL reset_a_data got %h want 0000", bus.a_data); end
    n_checks++; if (bus.b_data !== 16'h0000) begin n_fail++; $display("FAIL reset_b_data got %h want 0000", bus.b_data); end
    n_checks++; if (bus.a_count !== 8'd0) begin n_fail++; $display("FAIL reset_a_count got %0d want 0", bus.a_count); end
    n_checks++; if (bus.b_count !== 8'd0) begin n_fail++; $display("FAIL reset_b_count got %0d want 0", bus.b_count); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_a got %b want 1", bus.in_ready); end
    bus.s = 1'b1; #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_b got %b want 1", bus.in_ready); end
  endtask

  task automatic test_route_a();
    bus.s = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'hBEEF; bus.a_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.a_valid !== 1'b1) begin n_fail++; $display("FAIL route_a_valid got %b want 1", bus.a_valid); end
    n_checks++; if (bus.a_data !== 16'hBEEF) begin n_fail++; $display("FAIL route_a_data got %h want beef", bus.a_data); end
    n_checks++; if (bus.b_valid !== 1'b0) begin n_fail++; $display("FAIL route_a_b_valid got %b want 0", bus.b_valid); end
    n_checks++; if (bus.a_count !== 8'd0) begin n_fail++; $display("FAIL route_a_count0 got %0d want 0", bus.a_count); end
    step();
    n_checks++; if (bus.a_count !== 8'd1) begin n_fail++; $display("FAIL route_a_count1 got %0d want 1", bus.a_count); end
    n_checks++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL route_a_drain got %b want 0", bus.a_valid); end
    n_checks++; if (bus.a_data !== 16'hBEEF) begin n_fail++; $display("FAIL route_a_data_hold got %h want beef", bus.a_data); end
    bus.a_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    bus.s = 1'b1; bus.b_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h1234;
    step();
    n_checks++; if (bus.b_data !== 16'h1234) begin n_fail++; $display("FAIL bp_first got %h want 1234", bus.b_data); end
    bus.in_data = 16'h5678; #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
    step();
    n_checks++; if (bus.b_data !== 16'h1234) begin n_fail++; $display("FAIL bp_hold got %h want 1234", bus.b_data); end
    n_checks++; if (bus.b_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid got %b want 1", bus.b_valid); end
    n_checks++; if (bus.b_count !== 8'd0) begin n_fail++; $display("FAIL bp_count0 got %0d want 0", bus.b_count); end
    bus.b_ready = 1'b1; #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_refill_ready got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.b_data !== 16'h5678) begin n_fail++; $display("FAIL bp_refill_data got %h want 5678", bus.b_data); end
    n_checks++; if (bus.b_valid !== 1'b1) begin n_fail++; $display("FAIL bp_refill_valid got %b want 1", bus.b_valid); end
    n_checks++; if (bus.b_count !== 8'd1) begin n_fail++; $display("FAIL bp_count1 got %0d want 1", bus.b_count); end
    step();
    n_checks++; if (bus.b_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", bus.b_valid); end
    n_checks++; if (bus.b_count !== 8'd2) begin n_fail++; $display("FAIL bp_count2 got %0d want 2", bus.b_count); end
    bus.b_ready = 1'b0;
  endtask

  task automatic test_independence();
    bus.s = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h00AA;
    step();
    bus.s = 1'b0; bus.in_data = 16'h0001; bus.a_ready = 1'b1;
    step();
    n_checks++; if (bus.a_data !== 16'h0001) begin n_fail++; $display("FAIL ind_a1 got %h want 0001", bus.a_data); end
    bus.in_data = 16'h0002;
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.a_data !== 16'h0002) begin n_fail++; $display("FAIL ind_a2 got %h want 0002", bus.a_data); end
    n_checks++; if (bus.a_valid !== 1'b1) begin n_fail++; $display("FAIL ind_a2_valid got %b want 1", bus.a_valid); end
    step();
    n_checks++; if (bus.a_count !== 8'd3) begin n_fail++; $display("FAIL ind_a_count got %0d want 3", bus.a_count); end
    n_checks++; if (bus.b_valid !== 1'b1) begin n_fail++; $display("FAIL ind_b_valid got %b want 1", bus.b_valid); end
    n_checks++; if (bus.b_data !== 16'h00AA) begin n_fail++; $display("FAIL ind_b_data got %h want 00aa", bus.b_data); end
    n_checks++; if (bus.b_count !== 8'd2) begin n_fail++; $display("FAIL ind_b_count got %0d want 2", bus.b_count); end
    bus.a_ready = 1'b0;
  endtask

  task automatic test_enable_reset();
    bus.E = 1'b0; bus.s = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'hFFFF; bus.b_ready = 1'b1; #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL en_in_ready got %b want 0", bus.in_ready); end
    step();
    n_checks++; if (bus.b_valid !== 1'b0) begin n_fail++; $display("FAIL en_drain got %b want 0", bus.b_valid); end
    n_checks++; if (bus.b_count !== 8'd3) begin n_fail++; $display("FAIL en_b_count got %0d want 3", bus.b_count); end
    n_checks++; if (bus.b_data !== 16'h00AA) begin n_fail++; $display("FAIL en_b_data got %h want 00aa", bus.b_data); end
    bus.E = 1'b1; bus.b_ready = 1'b0; bus.s = 1'b0; bus.in_data = 16'h1111;
    step();
    bus.s = 1'b1; bus.in_data = 16'h2222;
    step();
    n_checks++; if ({bus.a_valid, bus.b_valid} !== 2'b11) begin n_fail++; $display("FAIL rst_pre_full got %b want 11", {bus.a_valid, bus.b_valid}); end
    rst = 1'b1; bus.a_ready = 1'b1; bus.b_ready = 1'b1;
    step();
    rst = 1'b0; bus.in_valid = 1'b0; bus.a_ready = 1'b0; bus.b_ready = 1'b0;
    n_checks++; if ({bus.a_valid, bus.b_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_valid got %b want 00", {bus.a_valid, bus.b_valid}); end
    n_checks++; if ({bus.a_count, bus.b_count} !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_count got %h want 0000", {bus.a_count, bus.b_count}); end
    n_checks++; if ({bus.a_data, bus.b_data} !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data got %h want 0", {bus.a_data, bus.b_data}); end
  endtask

  task automatic test_counter_wrap();
    bus.E = 1'b1; bus.s = 1'b0; bus.a_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.in_data = 16'(i);
      step();
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.a_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got %0d want 255", bus.a_count); end
    n_checks++; if (bus.a_data !== 16'h00FF) begin n_fail++; $display("FAIL wrap_last_data got %h want 00ff", bus.a_data); end
    step();
    n_checks++; if (bus.a_count !== 8'd0) begin n_fail++; $display("FAIL wrap_zero got %0d want 0", bus.a_count); end
    n_checks++; if (bus.b_count !== 8'd0) begin n_fail++; $display("FAIL wrap_b_count got %0d want 0", bus.b_count); end
    n_checks++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drained got %b want 0", bus.a_valid); end
    bus.a_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_route_a();
    test_back_pressure();
    test_independence();
    test_enable_reset();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_demux_1x2_16bit_reg

// File: doc/demux_1x2_16bit_reg.md
Name: demux_1x2_16bit_reg

Overview:
Registered 1-to-2 demultiplexer: the steering counterpart of the 16-bit 2-to-1 select mux. It takes one 16-bit datapath word per cycle and routes it to output A (s=0) or output B (s=1), with enable gating. The block sits between a producing pipeline stage and two consuming stages. Each output holds one registered entry with a valid/ready handshake, so back-pressure on one branch never corrupts the other.

Parameters:
WIDTH, 16, data word width in bits
CNT_W, 8, width of the per-output delivered-word counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
E  input  1  enable; 0 blocks acceptance of new words
s  input  1  route select; 0 selects output A, 1 selects output B
in_valid  input  1  in_data is valid this cycle
in_data  input  WIDTH  word to route
in_ready  output  1  block accepts the word this cycle
a_valid  output  1  output A holds a word
a_data  output  WIDTH  output A word
a_ready  input  1  consumer A takes the word this cycle
b_valid  output  1  output B holds a word
b_data  output  WIDTH  output B word
b_ready  input  1  consumer B takes the word this cycle
a_count  output  CNT_W  number of words delivered on A, modulo 2^CNT_W
b_count  output  CNT_W  number of words delivered on B, modulo 2^CNT_W

Behaviour:
- Single clock domain; reset is synchronous and active-high (clk, rst). All state updates on the rising edge of clk.
- Reset: a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0, b_count=0. Reset dominates every other event in the same cycle, including mid-transfer; held words are discarded.
- Slot free condition: slot X is free when X_valid=0, or when X_valid=1 and X_ready=1 (same-cycle drain and refill allowed).
- in_ready (combinational) = E AND (s ? B slot free : A slot free). in_ready does not depend on in_valid.
- Accept: accept = in_valid AND in_ready. On accept with s=0, a_data<=in_data and a_valid<=1. With s=1 the same applies to b_data and b_valid.
- Latency: exactly 1 cycle from accept to X_valid=1.
- Drain: X_valid=1 AND X_ready=1 with no refill in that cycle gives X_valid<=0. X_data holds its last value; it is not cleared.
- Hold: if X_valid=1 and X_ready=0, X_valid and X_data stay stable until taken. A valid word never changes.
- Non-selected output: unaffected by the input side. It may drain in the same cycle that the other output accepts.
- E=0: no acceptance. Held words still drain normally and counters still advance.
- s and in_data are sampled only when accept is true. If s changes while in_valid is stalled, the word goes to the new target.
- Counters: X_count increments by 1 on each cycle where X_valid AND X_ready is true. The counters wrap from 2^CNT_W-1 to 0 with no flag.
- No state machine beyond the per-output full/empty bit. Each output follows EMPTY to FULL on accept, FULL to EMPTY on drain without refill, and FULL to FULL on drain with refill or on a stall.
- Ready signals arriving while X_valid=0 are ignored.

Decomposition:
- Shared package holds WIDTH_DEFAULT=16, CNT_W_DEFAULT=8, and the route encoding constants ROUTE_A=1'b0 and ROUTE_B=1'b1.
- One natural sub-module: out_slot. It is a one-entry registered holding slot with load, valid/ready, and a delivered counter, instantiated twice (A and B). The top level contains only the in_ready/accept steering logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all valids 0, all data 0, counts 0, in_ready=1 when E=1.
- Route A: E=1, s=0, in_valid=1, in_data=16'hBEEF, a_ready=1 -> a_valid=1, a_data=16'hBEEF next cycle, b_valid stays 0, a_count=1 one cycle later.
- Back-pressure: s=1, send 16'h1234 with b_ready=0, then 16'h5678 -> in_ready=0 while B is full, b_data holds 16'h1234. Raising b_ready gives same-cycle refill; b_data becomes 16'h5678 with no bubble.
- Independence: B stalled full (b_ready=0) while s=0 words 16'h0001, 16'h0002 stream to A with a_ready=1 -> A gets both on consecutive cycles, a_count=2, B unchanged.
- Enable gating and reset mid-operation: E=0 with in_valid=1 -> in_ready=0, and a held word still drains. Asserting rst while a_valid=1 and b_valid=1 -> both 0 next cycle, counts 0.
- Counter wrap: CNT_W=8, deliver 256 words on A -> a_count returns to 0, b_count stays 0.
